// File: rtl/fifo_read_frame.sv
// rtl/fifo_read_frame.sv - pops NWORD words from the RX FIFO into one flat frame register
// Optional abort on err is built when FIFO_READ_ERR_ABORT_EN is defined.
module fifo_read_frame #(
   parameter int DW        = 8,
   parameter int NWORD     = 12,
   parameter int RD_LAT    = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fs,
   output logic                         fd,
   output logic                         fe,
   input  logic                         err,
   input  logic                         fifo_empty,
   output logic                         fifo_rxen,
   input  logic [DW-1:0]                fifo_rxd,
   output logic [DW*NWORD-1:0]          res,
   output logic [3:0]                   state_fr,
   output logic [$clog2(NWORD+1)-1:0]   word_cnt
);
   localparam int CW = $clog2(NWORD+1);
   localparam logic [CW-1:0] NWORD_C = CW'(NWORD);

`ifdef FIFO_READ_ERR_ABORT_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3
   } state_t;
`endif

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     req_cnt;
   logic [RD_LAT-1:0] rd_pipe;
   logic [CW-1:0]     slot;
   logic              busy;
   logic              abort_req;
   logic              capture;

   assign busy = (state == S_REQ) || (state == S_DRAIN);

`ifdef FIFO_READ_ERR_ABORT_EN
   assign abort_req = busy && err;
   assign fe        = (state == S_ABORT);
   assign fd        = (state == S_DONE) || (state == S_ABORT);
`else
   logic unused_err;
   assign unused_err = err;
   assign abort_req  = 1'b0;
   assign fe         = 1'b0;
   assign fd         = (state == S_DONE);
`endif

   assign fifo_rxen = (state == S_REQ) && !fifo_empty && (req_cnt < NWORD_C);
   // An abort in the same cycle drops the capture, so err wins over the final word.
   assign capture   = rd_pipe[RD_LAT-1] && busy && !abort_req && (word_cnt < NWORD_C);
   assign slot      = MSB_FIRST ? (NWORD_C - 1'b1 - word_cnt) : word_cnt;
   assign state_fr  = {1'b0, state};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         req_cnt  <= '0;
         word_cnt <= '0;
         rd_pipe  <= '0;
         res      <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && fs) begin
            req_cnt  <= '0;
            word_cnt <= '0;
         end
         if (fifo_rxen)
            req_cnt <= req_cnt + 1'b1;
         if (capture) begin
            res[slot*DW +: DW] <= fifo_rxd;
            word_cnt           <= word_cnt + 1'b1;
         end
         // Strobes still in flight are discarded between frames and on abort.
         if (state == S_IDLE || abort_req) begin
            rd_pipe <= '0;
         end else begin
            rd_pipe[0] <= fifo_rxen;
            for (int i = 1; i < RD_LAT; i++)
               rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   // DONE is entered the cycle after the final word lands in res.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (fs)
               state_nxt = S_REQ;
         end
         S_REQ: begin
`ifdef FIFO_READ_ERR_ABORT_EN
            if (abort_req)
               state_nxt = S_ABORT;
            else
`endif
            if (word_cnt == NWORD_C)
               state_nxt = S_DONE;
            else if (fifo_rxen && (req_cnt == NWORD_C - 1'b1))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
`ifdef FIFO_READ_ERR_ABORT_EN
            if (abort_req)
               state_nxt = S_ABORT;
            else
`endif
            if (word_cnt == NWORD_C)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            if (!fs)
               state_nxt = S_IDLE;
         end
`ifdef FIFO_READ_ERR_ABORT_EN
         S_ABORT: begin
            if (!fs)
               state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fifo_read_frame.sv
// tb/tb_fifo_read_frame.sv - directed bench for fifo_read_frame (default and RD_LAT=3/LSB-first builds)
module tb_fifo_read_frame;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic        fs, fd, fe, err, empty, rxen;
   logic [7:0]  rxd;
   logic [95:0] res;
   logic [3:0]  state_fr;
   logic [3:0]  word_cnt;

   logic        fs_b, fd_b, fe_b, err_b, empty_b, rxen_b;
   logic [7:0]  rxd_b;
   logic [95:0] res_b;
   logic [3:0]  state_fr_b;
   logic [3:0]  word_cnt_b;

   fifo_read_frame dut_a (
      .clk(clk), .rst(rst), .fs(fs), .fd(fd), .fe(fe), .err(err),
      .fifo_empty(empty), .fifo_rxen(rxen), .fifo_rxd(rxd), .res(res),
      .state_fr(state_fr), .word_cnt(word_cnt)
   );

   fifo_read_frame #(.DW(8), .NWORD(12), .RD_LAT(3), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .fs(fs_b), .fd(fd_b), .fe(fe_b), .err(err_b),
      .fifo_empty(empty_b), .fifo_rxen(rxen_b), .fifo_rxd(rxd_b), .res(res_b),
      .state_fr(state_fr_b), .word_cnt(word_cnt_b)
   );

   // FIFO models: word n popped carries base + n; data appears RD_LAT edges after the pop.
   int         pops_a = 0;
   int         pops_b = 0;
   logic [7:0] base_a = 8'h0;
   logic [7:0] base_b = 8'h0;
   logic [7:0] dq_a = 8'h0;
   logic [7:0] dq_b0 = 8'h0, dq_b1 = 8'h0, dq_b2 = 8'h0;

   always @(posedge clk) begin
      if (rxen) begin
         pops_a <= pops_a + 1;
         dq_a   <= base_a + pops_a[7:0];
      end
      if (rxen_b) begin
         pops_b <= pops_b + 1;
         dq_b0  <= base_b + pops_b[7:0];
      end
      dq_b1 <= dq_b0;
      dq_b2 <= dq_b1;
   end
   assign rxd   = dq_a;
   assign rxd_b = dq_b2;

   task automatic run_a(input int empty_at, input int err_at,
                        output int fd_edge, output int rx, output int rx_empty);
      int edges;
      edges = 0; rx = 0; rx_empty = 0; fd_edge = -1;
      fs = 1'b1;
      while (fd !== 1'b1 && edges < 200) begin
         @(negedge clk);
         edges++;
         if (edges == empty_at) empty = 1'b1;
         if (edges == empty_at + 5) empty = 1'b0;
         err = (edges == err_at);
         #1;
         if (rxen) begin
            rx++;
            if (empty) rx_empty++;
         end
      end
      empty = 1'b0;
      err   = 1'b0;
      if (fd === 1'b1) fd_edge = edges - 1;
   endtask

   task automatic test_reset;
      rst = 1'b1; fs = 1'b0; err = 1'b0; empty = 1'b0;
      fs_b = 1'b0; err_b = 1'b0; empty_b = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fd !== 1'b0) begin fails++; $display("FAIL reset_fd: got %0b expected 0", fd); end
      checks++; if (fe !== 1'b0) begin fails++; $display("FAIL reset_fe: got %0b expected 0", fe); end
      checks++; if (rxen !== 1'b0) begin fails++; $display("FAIL reset_rxen: got %0b expected 0", rxen); end
      checks++; if (res !== 96'h0) begin fails++; $display("FAIL reset_res: got %h expected 0", res); end
      checks++; if (state_fr !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_fr); end
      checks++; if (word_cnt !== 4'd0) begin fails++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
      checks++; if (res_b !== 96'h0 || fd_b !== 1'b0) begin fails++; $display("FAIL reset_b: res %h fd %0b expected 0 0", res_b, fd_b); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame;
      int fd_edge, rx, rx_empty, p0;
      base_a = 8'h01 - pops_a[7:0];
      p0 = pops_a;
      run_a(0, 0, fd_edge, rx, rx_empty);
      checks++; if (fd_edge !== 14) begin fails++; $display("FAIL frame_fd_edge: got %0d expected 14", fd_edge); end
      checks++; if (rx !== 12) begin fails++; $display("FAIL frame_rxen_cycles: got %0d expected 12", rx); end
      checks++; if (pops_a - p0 !== 12) begin fails++; $display("FAIL frame_pops: got %0d expected 12", pops_a - p0); end
      checks++; if (res !== 96'h0102030405060708090A0B0C) begin fails++; $display("FAIL frame_res: got %h expected 0102030405060708090a0b0c", res); end
      checks++; if (word_cnt !== 4'd12 || state_fr !== 4'd3 || fe !== 1'b0) begin fails++; $display("FAIL frame_done: word_cnt %0d state %0d fe %0b expected 12 3 0", word_cnt, state_fr, fe); end
      fs = 1'b0;
      @(negedge clk);
      checks++; if (fd !== 1'b0 || state_fr !== 4'd0) begin fails++; $display("FAIL frame_release: fd %0b state %0d expected 0 0", fd, state_fr); end
   endtask

   task automatic test_underrun;
      int fd_edge, rx, rx_empty, p0;
      base_a = 8'h01 - pops_a[7:0];
      p0 = pops_a;
      run_a(5, 0, fd_edge, rx, rx_empty);
      checks++; if (rx_empty !== 0) begin fails++; $display("FAIL underrun_rxen_when_empty: got %0d expected 0", rx_empty); end
      checks++; if (rx !== 12 || pops_a - p0 !== 12) begin fails++; $display("FAIL underrun_pops: rxen %0d pops %0d expected 12 12", rx, pops_a - p0); end
      checks++; if (fd_edge !== 19) begin fails++; $display("FAIL underrun_fd_edge: got %0d expected 19", fd_edge); end
      checks++; if (res !== 96'h0102030405060708090A0B0C) begin fails++; $display("FAIL underrun_res: got %h expected 0102030405060708090a0b0c", res); end
      fs = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lat3_lsb_first;
      int edges, rx, p0, fd_edge;
      edges = 0; rx = 0; fd_edge = -1;
      base_b = 8'h01 - pops_b[7:0];
      p0 = pops_b;
      fs_b = 1'b1;
      while (fd_b !== 1'b1 && edges < 200) begin
         @(negedge clk);
         edges++;
         #1;
         if (rxen_b) rx++;
      end
      if (fd_b === 1'b1) fd_edge = edges - 1;
      checks++; if (fd_edge !== 16) begin fails++; $display("FAIL lat3_fd_edge: got %0d expected 16", fd_edge); end
      checks++; if (rx !== 12 || pops_b - p0 !== 12) begin fails++; $display("FAIL lat3_pops: rxen %0d pops %0d expected 12 12", rx, pops_b - p0); end
      checks++; if (res_b !== 96'h0C0B0A090807060504030201) begin fails++; $display("FAIL lat3_res: got %h expected 0c0b0a090807060504030201", res_b); end
      fs_b = 1'b0;
      @(negedge clk);
      checks++; if (fd_b !== 1'b0 || state_fr_b !== 4'd0) begin fails++; $display("FAIL lat3_release: fd %0b state %0d expected 0 0", fd_b, state_fr_b); end
   endtask

   task automatic test_err;
      int fd_edge, rx, rx_empty, p0;
      base_a = 8'h21 - pops_a[7:0];
      p0 = pops_a;
      run_a(0, 8, fd_edge, rx, rx_empty);
`ifdef FIFO_READ_ERR_ABORT_EN
      checks++; if (fd_edge !== 8) begin fails++; $display("FAIL err_fd_edge: got %0d expected 8", fd_edge); end
      checks++; if (fe !== 1'b1 || rxen !== 1'b0 || state_fr !== 4'd4) begin fails++; $display("FAIL err_abort: fe %0b rxen %0b state %0d expected 1 0 4", fe, rxen, state_fr); end
      repeat (3) @(negedge clk);
      checks++; if (pops_a - p0 !== 8) begin fails++; $display("FAIL err_pops: got %0d expected 8", pops_a - p0); end
      checks++; if (word_cnt !== 4'd6 || res !== 96'h2122232425260708090A0B0C) begin fails++; $display("FAIL err_partial: word_cnt %0d res %h expected 6 2122232425260708090a0b0c", word_cnt, res); end
      fs = 1'b0;
      @(negedge clk);
      checks++; if (fe !== 1'b0 || fd !== 1'b0 || state_fr !== 4'd0) begin fails++; $display("FAIL err_release: fe %0b fd %0b state %0d expected 0 0 0", fe, fd, state_fr); end
`else
      checks++; if (fd_edge !== 14 || fe !== 1'b0) begin fails++; $display("FAIL err_ignored: fd_edge %0d fe %0b expected 14 0", fd_edge, fe); end
      checks++; if (pops_a - p0 !== 12 || res !== 96'h2122232425262728292A2B2C) begin fails++; $display("FAIL err_ignored_res: pops %0d res %h expected 12 2122232425262728292a2b2c", pops_a - p0, res); end
      fs = 1'b0;
      @(negedge clk);
`endif
   endtask

   task automatic test_reset_mid_frame;
      int fd_edge, rx, rx_empty, p0;
      base_a = 8'h31 - pops_a[7:0];
      p0 = pops_a;
      fs = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      fs  = 1'b0;
      #1;
      checks++; if (fd !== 1'b0 || fe !== 1'b0 || rxen !== 1'b0) begin fails++; $display("FAIL midrst_flags: fd %0b fe %0b rxen %0b expected 0 0 0", fd, fe, rxen); end
      checks++; if (res !== 96'h0 || state_fr !== 4'd0 || word_cnt !== 4'd0) begin fails++; $display("FAIL midrst_regs: res %h state %0d word_cnt %0d expected 0 0 0", res, state_fr, word_cnt); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (pops_a - p0 !== 5) begin fails++; $display("FAIL midrst_pops: got %0d expected 5", pops_a - p0); end
      run_a(0, 0, fd_edge, rx, rx_empty);
      checks++; if (fd_edge !== 14 || rx !== 12) begin fails++; $display("FAIL midrst_refill: fd_edge %0d rxen %0d expected 14 12", fd_edge, rx); end
      checks++; if (res !== 96'h363738393A3B3C3D3E3F4041) begin fails++; $display("FAIL midrst_res: got %h expected 363738393a3b3c3d3e3f4041", res); end
      fs = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_underrun();
      test_lat3_lsb_first();
      test_err();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
